// File: rtl/spiram_axi_slave.sv
// AXI4 slave front end for the SPI RAM: one burst at a time, each data beat
// becomes one word request on the mem_req/mem_ack port of the serial engine.
//
// Ports: S_AXI_* full AXI4 slave (AW/W/B/AR/R channels, sidebands ignored);
// mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb out, mem_ack/mem_rdata in.
module spiram_axi_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 24,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic                            S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic                            S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]   mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                            mem_ack,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [AW-3:0] WORD_ONE = {{(AW-3){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, WDATA, WMEM, WRESP, RMEM, RDATA} state_t;

    state_t                state;
    logic                  last_wr;
    logic [C_S_AXI_ID_WIDTH-1:0] id_q;
    logic [AW-3:0]         addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic                  incr_q;
    logic                  legal_q;
    logic                  err_q;
    logic                  last_q;

    logic legal_aw, legal_ar, at_len, w_end, w_bad;

    // Only FIXED/INCR full-word bursts reach the engine.
    assign legal_aw = !S_AXI_AWBURST[1] && (S_AXI_AWSIZE == 3'd2);
    assign legal_ar = !S_AXI_ARBURST[1] && (S_AXI_ARSIZE == 3'd2);
    assign at_len   = (beat_q == len_q);
    // Burst ends on WLAST or at len; disagreement between the two is an error.
    assign w_end    = S_AXI_WLAST || at_len;
    assign w_bad    = S_AXI_WLAST != at_len;

    assign mem_addr  = addr_q;
    assign S_AXI_BID = id_q;
    assign S_AXI_RID = id_q;

    logic unused_sideband;
    assign unused_sideband = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                               S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER,
                               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                               S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER,
                               S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= IDLE;
            last_wr       <= 1'b1;
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            incr_q        <= 1'b0;
            legal_q       <= 1'b0;
            err_q         <= 1'b0;
            last_q        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= OKAY;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= OKAY;
            S_AXI_RLAST   <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Round robin on a tie: serve the direction not granted last.
                    if (S_AXI_AWVALID && (!S_AXI_ARVALID || !last_wr)) begin
                        S_AXI_AWREADY <= 1'b1;
                        last_wr       <= 1'b1;
                        id_q          <= S_AXI_AWID;
                        addr_q        <= S_AXI_AWADDR[AW-1:2];
                        len_q         <= S_AXI_AWLEN;
                        incr_q        <= (S_AXI_AWBURST == 2'b01);
                        legal_q       <= legal_aw;
                        err_q         <= 1'b0;
                        beat_q        <= '0;
                        S_AXI_WREADY  <= 1'b1;
                        state         <= WDATA;
                    end else if (S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b1;
                        last_wr       <= 1'b0;
                        id_q          <= S_AXI_ARID;
                        addr_q        <= S_AXI_ARADDR[AW-1:2];
                        len_q         <= S_AXI_ARLEN;
                        incr_q        <= (S_AXI_ARBURST == 2'b01);
                        legal_q       <= legal_ar;
                        beat_q        <= '0;
                        mem_req       <= legal_ar;
                        mem_we        <= 1'b0;
                        state         <= RMEM;
                    end
                end
                WDATA: begin
                    if (S_AXI_WVALID) begin
                        if (w_bad) err_q <= 1'b1;
                        last_q <= w_end;
                        if (legal_q) begin
                            mem_req      <= 1'b1;
                            mem_we       <= 1'b1;
                            mem_wdata    <= S_AXI_WDATA;
                            mem_wstrb    <= S_AXI_WSTRB;
                            S_AXI_WREADY <= 1'b0;
                            state        <= WMEM;
                        end else if (w_end) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= SLVERR;
                            state        <= WRESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                WMEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (last_q) begin
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= err_q ? SLVERR : OKAY;
                            state        <= WRESP;
                        end else begin
                            S_AXI_WREADY <= 1'b1;
                            beat_q       <= beat_q + 8'd1;
                            if (incr_q) addr_q <= addr_q + WORD_ONE;
                            state        <= WDATA;
                        end
                    end
                end
                WRESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        S_AXI_BRESP  <= OKAY;
                        state        <= IDLE;
                    end
                end
                RMEM: begin
                    if (!legal_q) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RDATA  <= '0;
                        S_AXI_RRESP  <= SLVERR;
                        S_AXI_RLAST  <= at_len;
                        state        <= RDATA;
                    end else if (mem_ack) begin
                        mem_req      <= 1'b0;
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RDATA  <= mem_rdata;
                        S_AXI_RRESP  <= OKAY;
                        S_AXI_RLAST  <= at_len;
                        state        <= RDATA;
                    end
                end
                RDATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        if (at_len) begin
                            state <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            if (incr_q) addr_q <= addr_q + WORD_ONE;
                            mem_req <= legal_q;
                            state   <= RMEM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spiram_axi_slave.sv
// Directed bench for spiram_axi_slave: AXI master tasks plus a word-RAM
// engine that acks each request one cycle after it is first seen.
module tb_spiram_axi_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awid, arid, bid, rid;
    logic [23:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rlast, rvalid, rready;
    logic        mem_req, mem_we, mem_ack;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    spiram_axi_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0),
        .S_AXI_AWQOS(4'h0), .S_AXI_AWREGION(4'h0), .S_AXI_AWUSER(1'b0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
        .S_AXI_ARQOS(4'h0), .S_AXI_ARREGION(4'h0), .S_AXI_ARUSER(1'b0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Engine model and request log
    logic [31:0] mem [0:63];
    logic [21:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    logic [3:0]  log_strb [0:63];
    int nops = 0;
    int eng_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            eng_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (eng_cnt == 1) begin
                mem_ack = 1'b1;
                eng_cnt = 0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b])
                            mem[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata = mem[mem_addr[5:0]];
                end
                if (nops < 64) begin
                    log_addr[nops] = mem_addr;
                    log_data[nops] = mem_wdata;
                    log_strb[nops] = mem_wstrb;
                end
                nops++;
            end else begin
                eng_cnt = 1;
            end
        end
    end

    // Grant order: 1 = write, 0 = read
    logic gw [0:31];
    int gcnt = 0;
    always @(negedge clk) begin
        if (awready && gcnt < 32) begin gw[gcnt] = 1'b1; gcnt++; end
        if (arready && gcnt < 32) begin gw[gcnt] = 1'b0; gcnt++; end
    end

    logic        abort = 1'b0;
    logic [31:0] exp_r [0:15];

    task automatic do_write(input logic [23:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic id, input logic [31:0] d0,
                            input logic [3:0] strb, input int last_at,
                            input logic [1:0] exp_resp);
        int n;
        int nb;
        awaddr = a; awlen = len; awburst = burst; awsize = size; awid = id;
        awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!awready && n < 300 && !abort);
        if (abort) return;
        chk("aw_ready", 32'(awready), 32'd1);
        @(posedge clk); #1 awvalid = 1'b0;
        nb = (last_at < int'(len)) ? last_at : int'(len);
        for (int i = 0; i <= nb; i++) begin
            wdata = d0 + 32'(i); wstrb = strb; wlast = (i == last_at);
            wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end
            while (!wready && n < 300 && !abort);
            if (abort) return;
            chk("w_ready", 32'(wready), 32'd1);
            @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
        end
        bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bvalid && n < 300 && !abort);
        if (abort) return;
        chk("b_valid", 32'(bvalid), 32'd1);
        chk("b_resp", 32'(bresp), 32'(exp_resp));
        chk("b_id", 32'(bid), 32'(id));
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic id, input int stall,
                           input logic [1:0] exp_resp);
        int n;
        araddr = a; arlen = len; arburst = burst; arsize = size; arid = id;
        arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 300);
        chk("ar_ready", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!rvalid && n < 300);
            chk("r_valid", 32'(rvalid), 32'd1);
            for (int s = 0; s < stall; s++) begin
                chk("r_hold_data", rdata, exp_r[i]);
                chk("r_hold_last", 32'(rlast), 32'(i == int'(len)));
                chk("r_hold_id", 32'(rid), 32'(id));
                @(negedge clk);
            end
            chk("r_data", rdata, exp_r[i]);
            chk("r_last", 32'(rlast), 32'(i == int'(len)));
            chk("r_resp", 32'(rresp), 32'(exp_resp));
            chk("r_id", 32'(rid), 32'(id));
            rready = 1'b1;
            @(posedge clk); #1 rready = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int g;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0; bready = 0;
        rready = 0; awid = 0; arid = 0; awaddr = 0; araddr = 0;
        awlen = 0; arlen = 0; awsize = 0; arsize = 0; awburst = 0;
        arburst = 0; wdata = 0; wstrb = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie after reset: read first, then write
        g = gcnt;
        exp_r[0] = 32'h0;
        fork
            do_write(24'h20, 8'd0, 2'b01, 3'd2, 1'b1, 32'h11, 4'hF, 0, 2'b00);
            do_read(24'h0, 8'd0, 2'b01, 3'd2, 1'b1, 0, 2'b00);
        join
        chk("tie1_first_read", 32'(gw[g]), 32'd0);
        chk("tie1_then_write", 32'(gw[g+1]), 32'd1);

        // 8-beat INCR write and readback
        base = nops;
        do_write(24'h0, 8'd7, 2'b01, 3'd2, 1'b1, 32'd1, 4'hF, 7, 2'b00);
        chk("incr_nops", 32'(nops - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("incr_addr", 32'(log_addr[base+i]), 32'(i));
            chk("incr_data", log_data[base+i], 32'(i + 1));
            chk("incr_strb", 32'(log_strb[base+i]), 32'hF);
        end
        for (int i = 0; i < 8; i++) exp_r[i] = 32'(i + 1);
        do_read(24'h0, 8'd7, 2'b01, 3'd2, 1'b0, 0, 2'b00);

        // Tie after a read: write first
        g = gcnt;
        exp_r[0] = 32'h11;
        fork
            do_write(24'h24, 8'd0, 2'b01, 3'd2, 1'b0, 32'h22, 4'hF, 0, 2'b00);
            do_read(24'h20, 8'd0, 2'b01, 3'd2, 1'b0, 0, 2'b00);
        join
        chk("tie2_first_write", 32'(gw[g]), 32'd1);
        chk("tie2_then_read", 32'(gw[g+1]), 32'd0);

        // Partial strobe: word 4 held 5, low two bytes replaced
        base = nops;
        do_write(24'h10, 8'd0, 2'b01, 3'd2, 1'b0, 32'hAABBCCDD, 4'h3, 0, 2'b00);
        chk("strb_addr", 32'(log_addr[base]), 32'd4);
        chk("strb_strb", 32'(log_strb[base]), 32'h3);
        exp_r[0] = 32'h0000CCDD;
        do_read(24'h10, 8'd0, 2'b01, 3'd2, 1'b1, 0, 2'b00);

        // Stalled read: 4 beats, RREADY low 5 cycles each
        base = nops;
        for (int i = 0; i < 4; i++) exp_r[i] = 32'(i + 1);
        exp_r[3] = 32'd4;
        exp_r[0] = 32'd1;
        do_read(24'h0, 8'd3, 2'b01, 3'd2, 1'b1, 5, 2'b00);
        chk("stall_nops", 32'(nops - base), 32'd4);

        // FIXED burst keeps the address
        base = nops;
        do_write(24'h50, 8'd2, 2'b00, 3'd2, 1'b0, 32'h200, 4'hF, 2, 2'b00);
        chk("fixed_nops", 32'(nops - base), 32'd3);
        chk("fixed_addr0", 32'(log_addr[base]), 32'd20);
        chk("fixed_addr2", 32'(log_addr[base+2]), 32'd20);
        chk("fixed_data2", log_data[base+2], 32'h202);

        // Error bursts
        base = nops;
        do_write(24'h40, 8'd3, 2'b10, 3'd2, 1'b1, 32'h300, 4'hF, 3, 2'b10);
        chk("wrap_no_req", 32'(nops - base), 32'd0);
        for (int i = 0; i < 4; i++) exp_r[i] = 32'h0;
        do_read(24'h0, 8'd3, 2'b01, 3'd1, 1'b0, 0, 2'b10);
        chk("narrow_no_req", 32'(nops - base), 32'd0);

        // Early WLAST ends the burst after two beats with SLVERR
        base = nops;
        do_write(24'h30, 8'd3, 2'b01, 3'd2, 1'b0, 32'h100, 4'hF, 1, 2'b10);
        chk("early_nops", 32'(nops - base), 32'd2);

        // Reset during beat 3 of an 8-beat write
        base = nops;
        fork
            do_write(24'h0, 8'd7, 2'b01, 3'd2, 1'b1, 32'h50, 4'hF, 7, 2'b00);
            begin
                n = 0;
                do begin @(negedge clk); n++; end
                while (!(mem_req && !mem_ack && nops - base == 2) && n < 300);
                chk("rst_at_beat3", 32'(mem_req), 32'd1);
                chk("rst_beat_addr", 32'(mem_addr), 32'd2);
                #2 rst_n = 1'b0;
                abort = 1'b1;
                awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
                #1;
                chk("rst_req_drop", 32'(mem_req), 32'd0);
                chk("rst_wready_drop", 32'(wready), 32'd0);
                chk("rst_bvalid_drop", 32'(bvalid), 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        base = nops;
        do_write(24'h8, 8'd1, 2'b01, 3'd2, 1'b0, 32'h70, 4'hF, 1, 2'b00);
        chk("post_rst_nops", 32'(nops - base), 32'd2);
        chk("post_rst_addr", 32'(log_addr[base]), 32'd2);
        chk("post_rst_data", log_data[base+1], 32'h71);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
